weight_load_ctrl: RTL and testbench

Sequencer for the systolic array's weight buffer. It accepts `ARRAYWIDTH` row-beats of weights from an upstream source over a valid/ready handshake and drives the buffer's `load_en` and `in_weight` to shift those beats in. It then holds the weights resident until the array requests them. On request it asserts the buffer's `out_en` for exactly `ARRAYWIDTH` cycles. It sits between the weight fetch path and `weight_buffer`, and is the only driver of that buffer's control inputs.

---
 rtl/weight_load_ctrl.sv | 137 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
// ----------------
// This block sequences the weight buffer of the systolic array. In LOAD it
// accepts ARRAYWIDTH row-beats from the fetch path over a valid/ready
// handshake and strobes them into the buffer. It then holds in READY until the
// array asks for the weights. On that request it asserts the buffer's out_en
// for exactly ARRAYWIDTH cycles (DRAIN). After the last drain cycle it pulses
// done.
//
// Ports
//   clk           : clock; all state changes on its rising edge
//   rst           : synchronous active-high reset
//   start         : one-cycle pulse that begins a load (acted on in IDLE only)
//   abort         : synchronous cancel back to IDLE from any state
//   src_valid     : upstream beat valid
//   src_ready     : a beat is accepted this cycle when src_valid is also high
//   src_weight    : one row of weights; lane i is [(i+1)*DATASIZE-1 : i*DATASIZE]
//   drain_req     : array requests the weights (acted on in READY only)
//   buf_load_en   : weight_buffer.load_en
//   buf_out_en    : weight_buffer.out_en
//   buf_in_weight : weight_buffer.in_weight (combinational copy of src_weight)
//   loaded        : weights resident and not yet drained
//   busy          : controller is not IDLE
//   done          : one-cycle pulse after the final drain cycle
module weight_load_ctrl #(
    parameter int ARRAYWIDTH = 8,
    parameter int DATASIZE   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           src_valid,
    output logic                           src_ready,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] src_weight,
    input  logic                           drain_req,
    output logic                           buf_load_en,
    output logic                           buf_out_en,
    output logic [ARRAYWIDTH*DATASIZE-1:0] buf_in_weight,
    output logic                           loaded,
    output logic                           busy,
    output logic                           done
);

    localparam int            CW   = $clog2(ARRAYWIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(ARRAYWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    // The buffer samples in_weight only when load_en is high, so the row is
    // passed straight through in every state.
    assign buf_in_weight = src_weight;

    // State register. done is registered so that it lands in the cycle after
    // the final drain strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;

        // The strobes come from the current state only. An abort therefore
        // still lets the beat of this cycle go through, and it suppresses the
        // strobes of the next cycle.
        src_ready   = (state == LOAD);
        buf_out_en  = (state == DRAIN);
        loaded      = (state == READY);
        busy        = (state != IDLE);
        buf_load_en = src_valid & src_ready;

        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // start wins when it arrives together with drain_req.
                    // drain_req has no meaning in IDLE.
                    if (start) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end
                end
                LOAD: begin
                    if (buf_load_en) begin
                        if (cnt == LAST) begin
                            state_nxt = READY;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                READY: begin
                    if (drain_req) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end
                end
                DRAIN: begin
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Testbench for weight_load_ctrl with ARRAYWIDTH=4 and DATASIZE=8.
// Each stimulus cycle queues the hand-derived control outputs expected in that
// cycle. The vector packs {src_ready, buf_load_en, buf_out_en, loaded, busy,
// done}. Every row that should be strobed into the buffer is queued as well.
// A monitor on the falling edge pops both queues and compares them against
// the DUT.
module tb_weight_load_ctrl;

    localparam int AW = 4;
    localparam int DS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [AW*DS-1:0]  src_weight = '0;
    logic              drain_req = 1'b0;
    logic              buf_load_en;
    logic              buf_out_en;
    logic [AW*DS-1:0]  buf_in_weight;
    logic              loaded;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    weight_load_ctrl #(.ARRAYWIDTH(AW), .DATASIZE(DS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_weight    (src_weight),
        .drain_req     (drain_req),
        .buf_load_en   (buf_load_en),
        .buf_out_en    (buf_out_en),
        .buf_in_weight (buf_in_weight),
        .loaded        (loaded),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [5:0] exp;
        int         id;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] wq[$];
    int          vec_id = 0;
    int          total = 0;
    int          bad = 0;
    logic        fin_req = 1'b0;
    logic        fin_ack = 1'b0;

    logic [31:0] w1 [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    logic [31:0] w2 [4] = '{32'hA1B2C3D4, 32'h11223344, 32'hFFEE0080, 32'h5A5A7F01};
    int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    // in = {rst, start, abort, src_valid, drain_req}
    // e  = {src_ready, buf_load_en, buf_out_en, loaded, busy, done}
    task automatic step(input logic [4:0] in, input logic [31:0] w, input logic [5:0] e);
        vec_t v;
        @(posedge clk);
        #1;
        {rst, start, abort, src_valid, drain_req} = in;
        src_weight = w;
        v.exp = e;
        v.id  = vec_id;
        vec_id++;
        vq.push_back(v);
        if (e[4]) wq.push_back(w);
    endtask

    task automatic load4(input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
        step(5'b00010, b0, 6'b110010);
        step(5'b00010, b1, 6'b110010);
        step(5'b00010, b2, 6'b110010);
        step(5'b00010, b3, 6'b110010);
    endtask

    task automatic drain4();
        step(5'b00001, 32'h0, 6'b000110);
        repeat (4) step(5'b00000, 32'h0, 6'b001010);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        vec_t        v;
        logic [5:0]  act;
        logic [31:0] w;
        if (vq.size() > 0) begin
            v   = vq.pop_front();
            act = {src_ready, buf_load_en, buf_out_en, loaded, busy, done};
            total++;
            if (act !== v.exp) begin
                bad++;
                $display("FAIL ctrl_vec%0d got=%b want=%b (rdy,ld,out,loaded,busy,done)",
                         v.id, act, v.exp);
            end
        end
        if (buf_load_en === 1'b1) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_load got=%h want=no strobe", buf_in_weight);
            end else begin
                w = wq.pop_front();
                if (buf_in_weight !== w) begin
                    bad++;
                    $display("FAIL in_weight got=%h want=%h", buf_in_weight, w);
                end
            end
        end
        if (fin_req && !fin_ack) begin
            total++;
            if (vq.size() != 0 || wq.size() != 0) begin
                bad++;
                $display("FAIL leftover got=%0d/%0d entries want=0/0", vq.size(), wq.size());
            end
            fin_ack = 1'b1;
        end
    end

    initial begin
        // reset held two cycles, then idle with src_valid high and no start
        step(5'b10000, 32'h0, 6'b000000);
        step(5'b10000, 32'h0, 6'b000000);
        step(5'b00010, 32'hDEADBEEF, 6'b000000);
        step(5'b00010, 32'hDEADBEEF, 6'b000000);

        // clean load and drain
        step(5'b01000, 32'h0, 6'b000000);
        load4(w1[0], w1[1], w1[2], w1[3]);
        drain4();
        step(5'b00000, 32'h0, 6'b000001);
        step(5'b00000, 32'h0, 6'b000000);

        // stalled load; drain_req in LOAD stalls must be ignored
        step(5'b01000, 32'h0, 6'b000000);
        begin
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                if (pat[i] != 0) begin
                    step(5'b00010, w2[k], 6'b110010);
                    k++;
                end else begin
                    step(5'b00001, 32'hFFFFFFFF, 6'b100010);
                end
            end
        end
        // start in READY is ignored
        step(5'b01000, 32'h0, 6'b000110);
        step(5'b00000, 32'h0, 6'b000110);
        step(5'b00001, 32'h0, 6'b000110);
        // start in DRAIN is ignored
        repeat (4) step(5'b01000, 32'h0, 6'b001010);
        step(5'b00000, 32'h0, 6'b000001);

        // start together with drain_req in IDLE -> LOAD
        step(5'b01001, 32'h0, 6'b000000);
        step(5'b00000, 32'h0, 6'b100010);
        step(5'b00010, w1[0], 6'b110010);
        step(5'b00010, w1[1], 6'b110010);
        // abort after two beats
        step(5'b00100, 32'h0, 6'b100010);
        step(5'b00010, 32'h55555555, 6'b000000);
        // fresh start needs four new beats
        step(5'b01000, 32'h0, 6'b000000);
        load4(w2[0], w2[1], w2[2], w2[3]);
        step(5'b00001, 32'h0, 6'b000110);
        step(5'b00000, 32'h0, 6'b001010);
        step(5'b00000, 32'h0, 6'b001010);
        // rst on drain cycle 3
        step(5'b10000, 32'h0, 6'b001010);
        step(5'b00000, 32'h0, 6'b000000);
        step(5'b00000, 32'h0, 6'b000000);

        // back-to-back: start on the done cycle
        step(5'b01000, 32'h0, 6'b000000);
        load4(w1[0], w1[1], w1[2], w1[3]);
        drain4();
        step(5'b01000, 32'h0, 6'b000001);
        step(5'b00000, 32'h0, 6'b100010);
        load4(w2[0], w2[1], w2[2], w2[3]);
        drain4();
        step(5'b00000, 32'h0, 6'b000001);
        step(5'b00000, 32'h0, 6'b000000);

        fin_req = 1'b1;
        for (int i = 0; i < 20 && !fin_ack; i++) @(posedge clk);
        if (!fin_ack) begin
            $display("FAIL monitor_timeout got=no ack want=ack");
            $fatal(1, "monitor did not respond");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
